// File: rtl/ace_write_arb_pkg.sv
// Shared types, payload layout and round-robin helper
// for the ACE write-port arbiter.
package ace_write_arb_pkg;

  localparam int AWP_W_DEF = 58;
  localparam int WP_W_DEF  = 36;

  // AW payload bit offsets, LSB first
  localparam int AW_ADDR_OFF   = 0;
  localparam int AW_LEN_OFF    = 32;
  localparam int AW_SIZE_OFF   = 40;
  localparam int AW_BURST_OFF  = 43;
  localparam int AW_CACHE_OFF  = 45;
  localparam int AW_PROT_OFF   = 49;
  localparam int AW_LOCK_OFF   = 52;
  localparam int AW_SNOOP_OFF  = 53;
  localparam int AW_DOMAIN_OFF = 56;

  localparam int W_STRB_OFF = 0;
  localparam int W_DATA_OFF = 4;

  typedef enum logic [2:0] {
    SNP_WR_UNIQUE     = 3'b000,
    SNP_WR_LINE_UNIQ  = 3'b001,
    SNP_WR_CLEAN      = 3'b010,
    SNP_WR_BACK       = 3'b011,
    SNP_EVICT         = 3'b100,
    SNP_WR_EVICT      = 3'b101
  } awsnoop_t;

  typedef enum logic [1:0] {
    DOM_NON_SHARE = 2'b00,
    DOM_INNER     = 2'b01,
    DOM_OUTER     = 2'b10,
    DOM_SYSTEM    = 2'b11
  } awdomain_t;

  typedef enum logic [1:0] {
    BAR_NORMAL = 2'b00,
    BAR_MEMORY = 2'b01,
    BAR_IGNORE = 2'b10,
    BAR_SYNC   = 2'b11
  } awbar_t;

  typedef enum logic {
    AW_IDLE = 1'b0,
    AW_HOLD = 1'b1
  } aw_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(
    input logic [7:0] valid,
    input logic [2:0] ptr,
    input int         n
  );
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = 3'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ace_wr_order_fifo.sv
// Order FIFO holding the requester index of each
// AW-accepted burst whose W data is still pending.
module ace_wr_order_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ace_write_arbiter.sv
// Round-robin arbiter sharing one ACE write master
// port (AW/W/B) between NUM_REQ requesters.
module ace_write_arbiter
  import ace_write_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ID_W       = 4,
  parameter  int AWP_W      = AWP_W_DEF,
  parameter  int WP_W       = WP_W_DEF,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       s_awvalid,
  output logic [NUM_REQ-1:0]       s_awready,
  input  logic [NUM_REQ*ID_W-1:0]  s_awid,
  input  logic [NUM_REQ*AWP_W-1:0] s_awpayload,
  input  logic [NUM_REQ-1:0]       s_wvalid,
  output logic [NUM_REQ-1:0]       s_wready,
  input  logic [NUM_REQ-1:0]       s_wlast,
  input  logic [NUM_REQ*WP_W-1:0]  s_wpayload,
  output logic [NUM_REQ-1:0]       s_bvalid,
  input  logic [NUM_REQ-1:0]       s_bready,
  output logic [ID_W-1:0]          s_bid,
  output logic [1:0]               s_bresp,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [IDX_W+ID_W-1:0]    m_awid,
  output logic [AWP_W-1:0]         m_awpayload,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic                     m_wlast,
  output logic [WP_W-1:0]          m_wpayload,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  input  logic [IDX_W+ID_W-1:0]    m_bid,
  input  logic [1:0]               m_bresp
);

  aw_state_t        state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] lock_q, lock_d;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] pwin;
  rr_pick_t         pick;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] bidx;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] i
  );
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AW_IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    pick      = rr_pick(8'(s_awvalid), 3'(rr_q), NUM_REQ);
    pwin      = IDX_W'(pick.idx);
    state_d   = state_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    sel       = lock_q;
    m_awvalid = 1'b0;
    push      = 1'b0;
    s_awready = '0;
    if (rst_n) begin
      unique case (state_q)
        AW_IDLE: begin
          if (!full && pick.found) begin
            sel       = pwin;
            m_awvalid = 1'b1;
            if (m_awready) begin
              push = 1'b1;
              rr_d = nxt(pwin);
            end else begin
              lock_d  = pwin;
              state_d = AW_HOLD;
            end
          end
        end
        AW_HOLD: begin
          // Grant is frozen until the master accepts it
          m_awvalid = 1'b1;
          if (m_awready) begin
            push    = 1'b1;
            rr_d    = nxt(lock_q);
            state_d = AW_IDLE;
          end
        end
        default: ;
      endcase
    end
    s_awready[sel] = m_awvalid & m_awready;
  end

  assign m_awid      = {sel, s_awid[int'(sel)*ID_W +: ID_W]};
  assign m_awpayload = s_awpayload[int'(sel)*AWP_W +: AWP_W];

  ace_wr_order_fifo #(
    .W     (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_order (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    m_wvalid   = 1'b0;
    m_wlast    = 1'b0;
    s_wready   = '0;
    m_wpayload = s_wpayload[int'(head)*WP_W +: WP_W];
    if (!empty) begin
      m_wvalid       = s_wvalid[head];
      m_wlast        = s_wlast[head];
      s_wready[head] = m_wready;
    end
  end

  assign pop = m_wvalid & m_wready & m_wlast;

  assign bidx = m_bid[IDX_W+ID_W-1:ID_W];

  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b0;
    s_bid    = m_bid[ID_W-1:0];
    s_bresp  = m_bresp;
    if (rst_n) begin
      // Unmapped prefixes are sunk so the master never stalls
      if (int'(bidx) < NUM_REQ) begin
        s_bvalid[bidx] = m_bvalid;
        m_bready       = s_bready[bidx];
      end else begin
        m_bready = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ace_write_arbiter.sv
// Scoreboard bench for ace_write_arbiter: directed
// stimulus, expected beats queued, monitor compares.
module tb_ace_write_arbiter;

  localparam int N  = 2;
  localparam int IW = 4;
  localparam int AP = 58;
  localparam int WP = 36;
  localparam int BW = 5;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    s_awvalid;
  logic [N-1:0]    s_awready;
  logic [N*IW-1:0] s_awid;
  logic [N*AP-1:0] s_awpayload;
  logic [N-1:0]    s_wvalid;
  logic [N-1:0]    s_wready;
  logic [N-1:0]    s_wlast;
  logic [N*WP-1:0] s_wpayload;
  logic [N-1:0]    s_bvalid;
  logic [N-1:0]    s_bready;
  logic [IW-1:0]   s_bid;
  logic [1:0]      s_bresp;
  logic            m_awvalid;
  logic            m_awready;
  logic [BW-1:0]   m_awid;
  logic [AP-1:0]   m_awpayload;
  logic            m_wvalid;
  logic            m_wready;
  logic            m_wlast;
  logic [WP-1:0]   m_wpayload;
  logic            m_bvalid;
  logic            m_bready;
  logic [BW-1:0]   m_bid;
  logic [1:0]      m_bresp;

  ace_write_arbiter #(
    .NUM_REQ(N), .ID_W(IW), .AWP_W(AP),
    .WP_W(WP), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_awid(s_awid), .s_awpayload(s_awpayload),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_wlast(s_wlast), .s_wpayload(s_wpayload),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awid(m_awid), .m_awpayload(m_awpayload),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wlast(m_wlast), .m_wpayload(m_wpayload),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_bid(m_bid), .m_bresp(m_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [62:0] aw_q [$];
  logic [36:0] w_q [$];
  logic [7:0]  b_q [$];
  logic [62:0] aw_e;
  logic [36:0] w_e;
  logic [7:0]  b_e;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [AP-1:0] awp(int r, int t);
    return {32'(32'h8000_0000 + r*4096 + t*64),
            26'(t*3 + r + 1)};
  endfunction

  function automatic logic [WP-1:0] wpay(int r, int t, int b);
    return {32'(r*4096 + t*16 + b) ^ 32'hA5A5_0000,
            4'(15 - b)};
  endfunction

  task automatic exp_aw(input int r, input int id, input int t);
    aw_q.push_back({1'(r), 4'(id), awp(r, t)});
  endtask

  task automatic exp_w(input int r, input int t, input int nb);
    for (int b = 0; b < nb; b++)
      w_q.push_back({(b == nb-1), wpay(r, t, b)});
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (m_awvalid && m_awready) begin
      if (aw_q.size() == 0) begin
        chk("aw_unexpected", 64'(m_awid), 64'hFFFF);
      end else begin
        aw_e = aw_q.pop_front();
        chk("aw_id", 64'(m_awid), 64'(aw_e[62:58]));
        chk("aw_pay", 64'(m_awpayload), 64'(aw_e[57:0]));
      end
    end
    if (m_wvalid && m_wready) begin
      if (w_q.size() == 0) begin
        chk("w_unexpected", 64'(m_wpayload), 64'hFFFF);
      end else begin
        w_e = w_q.pop_front();
        chk("w_beat", 64'({m_wlast, m_wpayload}), 64'(w_e));
      end
    end
    if (|(s_bvalid & s_bready)) begin
      if (b_q.size() == 0) begin
        chk("b_unexpected", 64'(s_bvalid), 64'hFFFF);
      end else begin
        b_e = b_q.pop_front();
        chk("b_resp", 64'({s_bvalid, s_bid, s_bresp}), 64'(b_e));
      end
    end
  end

  task automatic aw_req(input int r, input int id, input int t);
    bit hs;
    hs = 1'b0;
    s_awvalid[r] = 1'b1;
    s_awid[r*IW +: IW] = 4'(id);
    s_awpayload[r*AP +: AP] = awp(r, t);
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = s_awready[r];
      @(posedge clk);
    end
    #1 s_awvalid[r] = 1'b0;
    if (!hs) chk("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic w_send(input int r, input int t, input int nb);
    bit hs;
    for (int b = 0; b < nb; b++) begin
      hs = 1'b0;
      s_wvalid[r] = 1'b1;
      s_wlast[r] = (b == nb-1);
      s_wpayload[r*WP +: WP] = wpay(r, t, b);
      for (int n = 0; n < 200 && !hs; n++) begin
        @(negedge clk);
        hs = s_wready[r];
        @(posedge clk);
      end
      #1;
      if (!hs) chk("w_timeout", 64'd0, 64'd1);
    end
    s_wvalid[r] = 1'b0;
    s_wlast[r] = 1'b0;
  endtask

  task automatic b_send(input logic [BW-1:0] id,
                        input logic [1:0] resp);
    bit hs;
    hs = 1'b0;
    m_bvalid = 1'b1;
    m_bid = id;
    m_bresp = resp;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk);
      hs = m_bready;
      @(posedge clk);
    end
    #1 m_bvalid = 1'b0;
    if (!hs) chk("b_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_awvalid = '0; s_awid = '0; s_awpayload = '0;
    s_wvalid = '0; s_wlast = '0; s_wpayload = '0;
    s_bready = '0;
    m_awready = 1'b1; m_wready = 1'b1;
    m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_bready", 64'(m_bready), 64'd0);
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester 1: awid 3, four beats, B back
    s_bready = 2'b11;
    exp_aw(1, 3, 1);
    exp_w(1, 1, 4);
    fork
      aw_req(1, 3, 1);
      w_send(1, 1, 4);
    join
    b_q.push_back({2'b10, 4'h3, 2'b00});
    b_send(5'h13, 2'b00);

    // Both requesters continuously valid
    exp_aw(0, 4'ha, 2); exp_aw(1, 4'hb, 3);
    exp_aw(0, 4'hc, 4); exp_aw(1, 4'hd, 5);
    exp_w(0, 2, 2); exp_w(1, 3, 2);
    exp_w(0, 4, 2); exp_w(1, 5, 2);
    fork
      begin aw_req(0, 4'ha, 2); aw_req(0, 4'hc, 4); end
      begin aw_req(1, 4'hb, 3); aw_req(1, 4'hd, 5); end
      begin w_send(0, 2, 2); w_send(0, 4, 2); end
      begin w_send(1, 3, 2); w_send(1, 5, 2); end
    join

    // AW stall on requester 1, requester 0 arrives late
    exp_aw(1, 4'he, 6); exp_aw(0, 4'h7, 7);
    m_awready = 1'b0;
    s_awvalid[1] = 1'b1;
    s_awid[IW +: IW] = 4'he;
    s_awpayload[AP +: AP] = awp(1, 6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid", 64'(m_awvalid), 64'd1);
      chk("hold_id", 64'(m_awid), 64'h1e);
      chk("hold_pay", 64'(m_awpayload), 64'(awp(1, 6)));
      @(posedge clk); #1;
      if (c == 0) begin
        s_awvalid[0] = 1'b1;
        s_awid[0 +: IW] = 4'h7;
        s_awpayload[0 +: AP] = awp(0, 7);
      end
    end
    m_awready = 1'b1;
    @(posedge clk); #1 s_awvalid[1] = 1'b0;
    @(posedge clk); #1 s_awvalid[0] = 1'b0;
    exp_w(1, 6, 1); exp_w(0, 7, 1);
    w_send(1, 6, 1);
    w_send(0, 7, 1);

    // Order FIFO fills, fifth AW waits for a wlast pop
    m_wready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_aw(0, t, 10 + t);
      aw_req(0, t, 10 + t);
    end
    s_awvalid[0] = 1'b1;
    s_awid[0 +: IW] = 4'h4;
    s_awpayload[0 +: AP] = awp(0, 14);
    @(negedge clk);
    chk("full_awvalid", 64'(m_awvalid), 64'd0);
    chk("full_awready", 64'(s_awready), 64'd0);
    @(posedge clk); #1 m_wready = 1'b1;
    exp_aw(0, 4, 14);
    for (int t = 0; t < 5; t++) exp_w(0, 10 + t, 1);
    fork
      aw_req(0, 4, 14);
      for (int t = 0; t < 5; t++) w_send(0, 10 + t, 1);
    join

    // B to requester 1 stalls, then req0 gets its B
    s_bready = 2'b01;
    b_q.push_back({2'b10, 4'h2, 2'b10});
    m_bvalid = 1'b1; m_bid = 5'h12; m_bresp = 2'b10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("b_stall_ready", 64'(m_bready), 64'd0);
      chk("b_stall_valid", 64'(s_bvalid), 64'h2);
    end
    @(posedge clk); #1 s_bready = 2'b11;
    @(posedge clk); #1;
    b_q.push_back({2'b01, 4'h5, 2'b00});
    m_bid = 5'h05; m_bresp = 2'b00;
    @(posedge clk); #1 m_bvalid = 1'b0;

    // Reset in the middle of a W burst and an AW stall
    exp_aw(0, 9, 20);
    aw_req(0, 9, 20);
    w_q.push_back({1'b0, wpay(0, 20, 0)});
    s_wvalid[0] = 1'b1; s_wlast[0] = 1'b0;
    s_wpayload[0 +: WP] = wpay(0, 20, 0);
    @(posedge clk); #1;
    s_wpayload[0 +: WP] = wpay(0, 20, 1);
    m_wready = 1'b0; m_awready = 1'b0; s_bready = '0;
    s_awvalid[1] = 1'b1;
    s_awid[IW +: IW] = 4'h6;
    @(negedge clk);
    chk("pre_rst_wvalid", 64'(m_wvalid), 64'd1);
    chk("pre_rst_awvalid", 64'(m_awvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    m_awready = 1'b1; m_wready = 1'b1; s_bready = 2'b11;
    m_bvalid = 1'b1; m_bid = 5'h01;
    #1;
    chk("arst_awvalid", 64'(m_awvalid), 64'd0);
    chk("arst_awready", 64'(s_awready), 64'd0);
    chk("arst_wvalid", 64'(m_wvalid), 64'd0);
    chk("arst_wready", 64'(s_wready), 64'd0);
    chk("arst_bvalid", 64'(s_bvalid), 64'd0);
    chk("arst_bready", 64'(m_bready), 64'd0);
    @(posedge clk); #1;
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Both valid after reset: requester 0 must win first
    exp_aw(0, 4'ha, 21); exp_aw(1, 4'hb, 22);
    exp_w(0, 21, 1); exp_w(1, 22, 1);
    fork
      aw_req(0, 4'ha, 21);
      aw_req(1, 4'hb, 22);
      w_send(0, 21, 1);
      w_send(1, 22, 1);
    join

    repeat (3) @(negedge clk);
    chk("queues_drained",
        64'(aw_q.size() + w_q.size() + b_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
